// File: rtl/prio_req_sequencer.sv
// prio_req_sequencer: collects sticky requests, feeds pend & mask to an external priority encoder,
// serves the winning index over valid/ready and tracks service/loss statistics.
module prio_req_sequencer #(
    parameter logic [7:0] NONE_CODE = 8'hF0,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      req_in,
    input  logic [15:0]      mask,
    output logic [15:0]      enc_in,
    input  logic [7:0]       enc_code,
    output logic             out_valid,
    output logic [3:0]       out_idx,
    input  logic             out_ready,
    output logic [15:0]      pend,
    output logic [CNT_W-1:0] served_cnt,
    output logic [CNT_W-1:0] lost_cnt,
    output logic             code_err
);
    typedef enum logic {IDLE, HOLD} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t      state, state_next;
    logic [15:0] mask_q, clr;
    logic        xfer, grant, bad, lost;
    // mask is registered so enc_in depends only on flops
    assign enc_in = pend & mask_q;
    always_comb begin
        xfer  = state == HOLD && out_ready;
        clr   = xfer ? 16'(1) << out_idx : '0;
        grant = state == IDLE && enc_code < 8'd16 && enc_in[enc_code[3:0]];
        bad   = state == IDLE && enc_code != NONE_CODE && !grant;
        lost  = |(req_in & pend & ~clr);
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;
    always_comb
        state_next = state == IDLE ? (grant ? HOLD : IDLE) : (out_ready ? IDLE : HOLD);
    always_comb
        out_valid = state == HOLD;
    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            mask_q     <= '0;
            out_idx    <= '0;
            served_cnt <= '0;
            lost_cnt   <= '0;
            code_err   <= 1'b0;
        end else begin
            pend   <= (pend & ~clr) | req_in;
            mask_q <= mask;
            if (grant)
                out_idx <= enc_code[3:0];
            if (xfer && served_cnt != CNT_MAX)
                served_cnt <= served_cnt + 1'b1;
            if (lost && lost_cnt != CNT_MAX)
                lost_cnt <= lost_cnt + 1'b1;
            if (bad)
                code_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_prio_req_sequencer.sv
// tb_prio_req_sequencer: directed scenarios against prio_req_sequencer with a behavioural
// priority encoder in the loop and an override for injecting malformed codes.
module tb_prio_req_sequencer;
    logic        clk = 0;
    logic        rst = 1;
    logic [15:0] req_in = '0;
    logic [15:0] mask = 16'hFFFF;
    logic [15:0] enc_in;
    logic [7:0]  enc_code, enc_model, force_code = '0;
    logic        force_en = 0;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic        out_ready = 0;
    logic [15:0] pend;
    logic [7:0]  served_cnt, lost_cnt;
    logic        code_err;
    int          n_checks = 0;
    int          n_fail = 0;

    prio_req_sequencer dut (
        .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .enc_in(enc_in),
        .enc_code(enc_code), .out_valid(out_valid), .out_idx(out_idx), .out_ready(out_ready),
        .pend(pend), .served_cnt(served_cnt), .lost_cnt(lost_cnt), .code_err(code_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        enc_model = 8'hF0;
        for (int i = 0; i < 16; i++)
            if (enc_in[i]) enc_model = 8'(i);
    end
    assign enc_code = force_en ? force_code : enc_model;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req_in = 16'hFFFF; out_ready = 0;
        tick();
        n_checks++; if (pend !== 16'h0) begin n_fail++; $display("FAIL reset_pend got %h want 0000", pend); end
        n_checks++; if (enc_in !== 16'h0) begin n_fail++; $display("FAIL reset_enc_in got %h want 0000", enc_in); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (out_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", out_idx); end
        n_checks++; if (served_cnt !== 8'd0 || lost_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnts got %0d/%0d want 0/0", served_cnt, lost_cnt); end
        n_checks++; if (code_err !== 1'b0) begin n_fail++; $display("FAIL reset_code_err got %b want 0", code_err); end
        rst = 0; req_in = '0;
    endtask

    task automatic test_single();
        mask = 16'hFFFF; req_in = 16'h0001; out_ready = 1;
        tick();
        req_in = '0;
        n_checks++; if (out_valid !== 1'b0 || pend !== 16'h0001) begin n_fail++; $display("FAIL single_latency1 got valid=%b pend=%h want 0/0001", out_valid, pend); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0) begin n_fail++; $display("FAIL single_grant got valid=%b idx=%0d want 1/0", out_valid, out_idx); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || pend !== 16'h0) begin n_fail++; $display("FAIL single_clear got valid=%b pend=%h want 0/0000", out_valid, pend); end
        n_checks++; if (served_cnt !== 8'd1) begin n_fail++; $display("FAIL single_served got %0d want 1", served_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_idx [4] = '{4'd15, 4'd10, 4'd5, 4'd0};
        req_in = 16'h8421; out_ready = 1;
        tick();
        req_in = '0;
        n_checks++; if (pend !== 16'h8421) begin n_fail++; $display("FAIL b2b_pend got %h want 8421", pend); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_idx !== exp_idx[k]) begin n_fail++; $display("FAIL b2b_grant%0d got valid=%b idx=%0d want 1/%0d", k, out_valid, out_idx, exp_idx[k]); end
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap%0d got valid=%b want 0", k, out_valid); end
        end
        n_checks++; if (pend !== 16'h0 || served_cnt !== 8'd5) begin n_fail++; $display("FAIL b2b_final got pend=%h served=%0d want 0000/5", pend, served_cnt); end
    endtask

    task automatic test_stall();
        out_ready = 0; req_in = 16'h0010;
        tick();
        req_in = '0;
        tick();
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_idx !== 4'd4) begin n_fail++; $display("FAIL stall_hold%0d got valid=%b idx=%0d want 1/4", i, out_valid, out_idx); end
            req_in = (i == 3) ? 16'h8000 : 16'h0;
            mask = (i >= 5 && i < 9) ? 16'h0000 : 16'hFFFF;
            tick();
        end
        req_in = '0;
        n_checks++; if (pend !== 16'h8010 || out_idx !== 4'd4) begin n_fail++; $display("FAIL stall_pend got pend=%h idx=%0d want 8010/4", pend, out_idx); end
        out_ready = 1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || pend !== 16'h8000) begin n_fail++; $display("FAIL stall_release got valid=%b pend=%h want 0/8000", out_valid, pend); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 4'd15) begin n_fail++; $display("FAIL stall_next got valid=%b idx=%0d want 1/15", out_valid, out_idx); end
        tick();
        n_checks++; if (served_cnt !== 8'd7 || lost_cnt !== 8'd0) begin n_fail++; $display("FAIL stall_cnts got %0d/%0d want 7/0", served_cnt, lost_cnt); end
    endtask

    task automatic test_same_bit();
        out_ready = 0; req_in = 16'h0008;
        tick();
        req_in = '0;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 4'd3) begin n_fail++; $display("FAIL same_grant got valid=%b idx=%0d want 1/3", out_valid, out_idx); end
        req_in = 16'h0008; out_ready = 1;
        tick();
        req_in = '0; out_ready = 0;
        n_checks++; if (pend !== 16'h0008 || lost_cnt !== 8'd0 || served_cnt !== 8'd8) begin n_fail++; $display("FAIL same_set_wins got pend=%h lost=%0d served=%0d want 0008/0/8", pend, lost_cnt, served_cnt); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 4'd3) begin n_fail++; $display("FAIL same_regrant got valid=%b idx=%0d want 1/3", out_valid, out_idx); end
        req_in = 16'h0008;
        tick();
        n_checks++; if (lost_cnt !== 8'd1) begin n_fail++; $display("FAIL lost_first got %0d want 1", lost_cnt); end
        for (int i = 1; i < 254; i++) tick();
        n_checks++; if (lost_cnt !== 8'd254) begin n_fail++; $display("FAIL lost_254 got %0d want 254", lost_cnt); end
        for (int i = 254; i < 300; i++) tick();
        n_checks++; if (lost_cnt !== 8'd255) begin n_fail++; $display("FAIL lost_sat got %0d want 255", lost_cnt); end
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 4'd3) begin n_fail++; $display("FAIL lost_hold got valid=%b idx=%0d want 1/3", out_valid, out_idx); end
        req_in = '0; out_ready = 1;
        tick();
        out_ready = 0;
        n_checks++; if (served_cnt !== 8'd9 || pend !== 16'h0) begin n_fail++; $display("FAIL same_final got served=%0d pend=%h want 9/0000", served_cnt, pend); end
    endtask

    task automatic test_mask();
        mask = 16'h00FF; req_in = 16'hFF00;
        tick();
        req_in = '0;
        tick();
        tick();
        n_checks++; if (enc_in !== 16'h0 || out_valid !== 1'b0 || pend !== 16'hFF00) begin n_fail++; $display("FAIL mask_block got enc=%h valid=%b pend=%h want 0000/0/FF00", enc_in, out_valid, pend); end
        mask = 16'hFFFF;
        tick();
        n_checks++; if (enc_in !== 16'hFF00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mask_open got enc=%h valid=%b want FF00/0", enc_in, out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 4'd15) begin n_fail++; $display("FAIL mask_grant got valid=%b idx=%0d want 1/15", out_valid, out_idx); end
    endtask

    task automatic test_code_err();
        rst = 1; tick(); rst = 0;
        force_en = 1; force_code = 8'h20;
        tick();
        n_checks++; if (code_err !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL err_range got err=%b valid=%b want 1/0", code_err, out_valid); end
        force_code = 8'hF0;
        tick();
        n_checks++; if (code_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", code_err); end
        rst = 1; tick(); rst = 0;
        n_checks++; if (code_err !== 1'b0) begin n_fail++; $display("FAIL err_rst got %b want 0", code_err); end
        force_code = 8'h07; req_in = 16'h0001;
        tick();
        req_in = '0;
        n_checks++; if (code_err !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL err_bit got err=%b valid=%b want 1/0", code_err, out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || pend !== 16'h0001) begin n_fail++; $display("FAIL err_nogrant got valid=%b pend=%h want 0/0001", out_valid, pend); end
        force_en = 0;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0) begin n_fail++; $display("FAIL err_recover got valid=%b idx=%0d want 1/0", out_valid, out_idx); end
    endtask

    task automatic test_reset_mid_hold();
        rst = 1; out_ready = 1; req_in = 16'hFFFF;
        tick();
        rst = 0; req_in = '0; out_ready = 0;
        n_checks++; if (out_valid !== 1'b0 || out_idx !== 4'd0 || pend !== 16'h0) begin n_fail++; $display("FAIL rsthold_state got valid=%b idx=%0d pend=%h want 0/0/0000", out_valid, out_idx, pend); end
        n_checks++; if (served_cnt !== 8'd0 || lost_cnt !== 8'd0 || code_err !== 1'b0) begin n_fail++; $display("FAIL rsthold_stats got %0d/%0d/%b want 0/0/0", served_cnt, lost_cnt, code_err); end
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0 || pend !== 16'h0) begin n_fail++; $display("FAIL rsthold_discard got valid=%b pend=%h want 0/0000", out_valid, pend); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_same_bit();
        test_mask();
        test_code_err();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
